io_arbiter: RTL and testbench

- Shares the single-port IO memory between two requesters: CPU data port (m0) and DMA/peripheral engine (m1).
- Arbitrates round-robin and runs one access per grant through a 3-state FSM.
- Drives the IO memory's ce/we/addr/dataIn and returns registered read data with a one-cycle ack pulse.
- Sits between the MEM-stage address decode / DMA engine and the IO memory.

---
 rtl/io_arbiter_pkg.sv | 25 ++
 rtl/io_arbiter_if.sv | 33 +++
 rtl/io_arb_rr.sv | 21 ++
 rtl/io_arbiter.sv | 139 +++++++++++++
 tb/tb_io_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_arbiter_pkg.sv
// Shared encodings for the IO memory arbiter: RAM control levels, FSM states, master IDs.
// Optional build macro IO_ARB_LOCK_EN (see io_arbiter.sv).
package io_arbiter_pkg;

  localparam logic RamEnable  = 1'b1;
  localparam logic RamDisable = 1'b0;
  localparam logic RamWrite   = 1'b1;
  localparam logic RamRead    = 1'b0;
  localparam logic [31:0] Zero = 32'h0000_0000;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbAccess = 2'd1,
    ArbDone   = 2'd2
  } arb_state_e;

  localparam logic ArbM0 = 1'b0;
  localparam logic ArbM1 = 1'b1;

  // Word accesses only; any low address bit set is an error.
  function automatic logic misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/io_arbiter_if.sv
// Requester-side bus into the IO arbiter; one instance per master.
// With IO_ARB_LOCK_EN defined the bus also carries a lock request.
interface io_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
`ifdef IO_ARB_LOCK_EN
  logic              lock;
`endif

  modport master (
    output req, we, addr, wdata,
`ifdef IO_ARB_LOCK_EN
    output lock,
`endif
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef IO_ARB_LOCK_EN
    input  lock,
`endif
    output ack, rdata, err
  );
endinterface

// File: rtl/io_arb_rr.sv
// Combinational 2-way round-robin picker: on contention the master not served last wins.
module io_arb_rr
  import io_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic sel
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      sel = (last == ArbM0) ? ArbM1 : ArbM0;
    end else begin
      sel = req1 ? ArbM1 : ArbM0;
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Two-master round-robin arbiter for the single-port IO memory, one access per grant.
// Build macro IO_ARB_LOCK_EN adds per-master lock for back-to-back burst accesses.
module io_arbiter
  import io_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  io_arbiter_if.slave       m0,
  io_arbiter_if.slave       m1,
  output logic              io_ce,
  output logic              io_we,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              err_q, ack0_q, ack1_q;

  logic              rr_valid, rr_sel;
  logic              g_we, g_mis, other_req, hold_lock;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  io_arb_rr u_rr (
    .req0  (m0.req),
    .req1  (m1.req),
    .last  (last_q),
    .valid (rr_valid),
    .sel   (rr_sel)
  );

  always_comb begin
    g_we      = (gnt_q == ArbM1) ? m1.we    : m0.we;
    g_addr    = (gnt_q == ArbM1) ? m1.addr  : m0.addr;
    g_wdata   = (gnt_q == ArbM1) ? m1.wdata : m0.wdata;
    other_req = (gnt_q == ArbM1) ? m0.req   : m1.req;
    g_mis     = misaligned(g_addr[1:0]);
  end

`ifdef IO_ARB_LOCK_EN
  assign hold_lock = (gnt_q == ArbM1) ? (m1.lock & m1.req) : (m0.lock & m0.req);
`else
  assign hold_lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ArbIdle;
      gnt_q   <= ArbM0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ArbIdle: begin
        if (rr_valid) begin
          gnt_d   = rr_sel;
          state_d = ArbAccess;
        end
      end
      ArbAccess: state_d = ArbDone;
      ArbDone: begin
        // The granted master's own req is only honoured here under lock.
        if (hold_lock) begin
          state_d = ArbAccess;
        end else if (other_req) begin
          gnt_d   = ~gnt_q;
          state_d = ArbAccess;
        end else begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  always_comb begin
    io_ce    = RamDisable;
    io_we    = RamRead;
    io_addr  = ADDR_W'(Zero);
    io_wdata = DATA_W'(Zero);
    if (state_q == ArbAccess) begin
      io_ce    = g_mis ? RamDisable : RamEnable;
      io_we    = g_we;
      io_addr  = g_addr;
      io_wdata = g_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= ArbM1;
      rdata0_q <= DATA_W'(Zero);
      rdata1_q <= DATA_W'(Zero);
      err_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      if (state_q == ArbAccess) begin
        last_q <= gnt_q;
        err_q  <= g_mis;
        if (gnt_q == ArbM0) begin
          ack0_q <= 1'b1;
        end else begin
          ack1_q <= 1'b1;
        end
        if ((g_we == RamRead) && !g_mis) begin
          if (gnt_q == ArbM0) begin
            rdata0_q <= io_rdata;
          end else begin
            rdata1_q <= io_rdata;
          end
        end
      end
    end
  end

  assign m0.ack   = ack0_q;
  assign m0.rdata = rdata0_q;
  assign m0.err   = err_q & ack0_q;
  assign m1.ack   = ack1_q;
  assign m1.rdata = rdata1_q;
  assign m1.err   = err_q & ack1_q;

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: behavioural IO memory, per-master expected-result queues.
module tb_io_arbiter;
  import io_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          io_ce, io_we;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata, io_rdata;
  logic          mem_init = 1'b1;
  logic [31:0]   iomem   [0:255];
  logic [31:0]   ref_mem [0:255];
  logic [31:0]   last_rd [0:1];
  exp_t          q0[$];
  exp_t          q1[$];
  int            errors = 0;
  int            checks = 0;
  int            ce_cnt = 0;

  always #5 clk = ~clk;

  io_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  io_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  io_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .io_ce    (io_ce),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata)
  );

  assign io_rdata = iomem[io_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) iomem[i] <= 32'hA500_0000 + 32'(i);
    end else if (io_ce == RamEnable && io_we == RamWrite) begin
      iomem[io_addr[9:2]] <= io_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation of that master.
  always @(negedge clk) begin
    exp_t e;
    if (io_ce === RamEnable) ce_cnt++;
    if (m0_if.ack === 1'b1) begin
      chk("m0_ack_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("m0_rdata", m0_if.rdata, e.rdata);
        chk("m0_err", 32'(m0_if.err), 32'(e.err));
      end
    end
    if (m1_if.ack === 1'b1) begin
      chk("m1_ack_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("m1_rdata", m1_if.rdata, e.rdata);
        chk("m1_err", 32'(m1_if.err), 32'(e.err));
      end
    end
  end

  // Bench model of one transaction's outcome, pushed at drive time.
  task automatic expect_txn(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    exp_t e;
    if (addr[1:0] != 2'b00) begin
      e.rdata = last_rd[m];
      e.err   = 1'b1;
    end else if (we) begin
      ref_mem[addr[9:2]] = wdata;
      e.rdata = last_rd[m];
      e.err   = 1'b0;
    end else begin
      last_rd[m] = ref_mem[addr[9:2]];
      e.rdata = last_rd[m];
      e.err   = 1'b0;
    end
    if (m == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (m == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  // Single transaction; n counts negedges from drive to ack (3 when uncontended).
  task automatic txn(input string tag, input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int exp_ce);
    int n;
    @(posedge clk); #1;
    ce_cnt = 0;
    expect_txn(m, we, addr, wdata);
    drive(m, 1'b1, we, addr, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_of(m) !== 1'b1 && n < 20);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_ce_cycles"}, 32'(ce_cnt), 32'(exp_ce));
  endtask

  // Both masters read at once; optionally m0 follows its first ack with a second read.
  task automatic contend(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                         input bit cont, input logic [31:0] a0b);
    int n, t0a, t0b, t1;
    @(posedge clk); #1;
    t0a = 0; t0b = 0; t1 = 0;
    expect_txn(0, 1'b0, a0, 32'h0);
    expect_txn(1, 1'b0, a1, 32'h0);
    drive(0, 1'b1, 1'b0, a0, 32'h0);
    drive(1, 1'b1, 1'b0, a1, 32'h0);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (m0_if.ack === 1'b1) begin
        if (t0a == 0) begin
          t0a = n;
          if (cont) begin
            expect_txn(0, 1'b0, a0b, 32'h0);
            drive(0, 1'b1, 1'b0, a0b, 32'h0);
          end else begin
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
          end
        end else begin
          t0b = n;
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
      if (m1_if.ack === 1'b1) begin
        t1 = n;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (t1 != 0 && (t0b != 0 || (!cont && t0a != 0))) break;
    end
    chk({tag, "_m0_ack_cycle"}, 32'(t0a), 32'd3);
    chk({tag, "_m1_ack_cycle"}, 32'(t1), 32'd5);
    if (cont) chk({tag, "_m0_second_ack_cycle"}, 32'(t0b), 32'd7);
  endtask

  initial begin
    int n, acks, first_ack, last_ack;
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, first_ack, last_ack;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 + 32'(i);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef IO_ARB_LOCK_EN
    m0_if.lock = 1'b0;
    m1_if.lock = 1'b0;
`endif
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("reset_io_ce", 32'(io_ce), 32'(RamDisable));
    chk("reset_io_addr", io_addr, 32'h0);
    chk("reset_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("reset_m1_ack", 32'(m1_if.ack), 32'd0);
    chk("reset_m0_rdata", m0_if.rdata, 32'h0);
    chk("reset_m1_rdata", m1_if.rdata, 32'h0);
    rst = 1'b1;

    contend("contend", 32'h10, 32'h14, 1'b1, 32'h18);

    txn("m0_write", 0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
    txn("m0_read", 0, 1'b0, 32'h10, 32'h0, 1);

    txn("m1_misaligned", 1, 1'b0, 32'h6, 32'h0, 0);
    @(negedge clk);
    chk("m1_err_gated", 32'(m1_if.err), 32'd0);

    // m1 holds req for 9 cycles: one access per 3 cycles.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) expect_txn(1, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
    acks = 0; first_ack = 0; last_ack = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (m1_if.ack === 1'b1) begin
        acks++;
        if (first_ack == 0) first_ack = c;
        last_ack = c;
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("held_ack_count", 32'(acks), 32'd3);
    chk("held_first_ack", 32'(first_ack), 32'd3);
    chk("held_ack_span", 32'(last_ack - first_ack), 32'd6);

    // Reset during ACCESS of a write: nothing commits, no ack.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ce_in_access", 32'(io_ce), 32'(RamEnable));
    rst = 1'b0;
    #1;
    chk("abort_ce_dropped", 32'(io_ce), 32'(RamDisable));
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(negedge clk);
    chk("abort_no_ack", 32'(m0_if.ack), 32'd0);
    chk("abort_rdata_cleared", m0_if.rdata, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    contend("post_reset_contend", 32'h24, 32'h28, 1'b0, 32'h0);
    txn("read_after_abort", 0, 1'b0, 32'h20, 32'h0, 1);

`ifdef IO_ARB_LOCK_EN
    begin
      int k0, t1;
      int t0 [0:3];
      @(posedge clk); #1;
      k0 = 0; t1 = 0;
      m0_if.lock = 1'b1;
      expect_txn(0, 1'b0, 32'h0, 32'h0);
      drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (c == 1) begin
          expect_txn(1, 1'b0, 32'h40, 32'h0);
          drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        end
        if (m0_if.ack === 1'b1 && k0 < 4) begin
          t0[k0] = c;
          k0++;
          if (k0 < 4) begin
            expect_txn(0, 1'b0, 32'(k0 * 4), 32'h0);
            drive(0, 1'b1, 1'b0, 32'(k0 * 4), 32'h0);
          end else begin
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            m0_if.lock = 1'b0;
          end
        end
        if (m1_if.ack === 1'b1) begin
          t1 = c;
          drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
          break;
        end
      end
      chk("lock_m0_acks", 32'(k0), 32'd4);
      for (int k = 0; k < 4; k++) chk("lock_m0_ack_cycle", 32'(t0[k]), 32'(3 + 2 * k));
      chk("lock_m1_ack_cycle", 32'(t1), 32'd11);
    end
`endif

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
